// File: rtl/video_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// video_pkg : attribute layout, colour constants and helpers for text video
// Rev 1.0
// ---------------------------------------------------------------------------
package video_pkg;

  localparam int c_ATTR_UL    = 7;
  localparam int c_PAPER_MSB  = 6;
  localparam int c_PAPER_LSB  = 4;
  localparam int c_BRIGHT     = 3;
  localparam int c_INK_MSB    = 2;
  localparam int c_INK_LSB    = 0;

  localparam logic [7:0] c_INK_ON    = 8'hC0;
  localparam logic [7:0] c_BRIGHT_ON = 8'h3F;
  localparam logic [7:0] c_PAPER_ON  = 8'hFF;
  localparam logic [7:0] c_MONO_G    = 8'hC0;
  localparam logic [7:0] c_MONO_B    = 8'h0B;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic int clog2(input int v);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) n = i + 1;
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/text_cell_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// text_cell_fetch : char/attr/font fetch pipeline with underline+cursor overlay
// Rev 1.0
// ---------------------------------------------------------------------------
module text_cell_fetch
  import video_pkg::*;
#(
  parameter int AW     = 11,
  parameter int CHAR_H = 10,
  parameter int NCELLS = 1600
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_cell,
  input  logic [3:0]    i_line,
  input  logic          i_cursor_en,
  input  logic          i_blink,
  input  logic [AW-1:0] i_cursor_pos,
  output logic [AW-1:0] o_text_addr,
  output logic          o_text_rd,
  input  logic [7:0]    i_char_q,
  input  logic [7:0]    i_attr_q,
  output logic [11:0]   o_font_addr,
  output logic          o_font_rd,
  input  logic [7:0]    i_font_q,
  output logic [7:0]    o_shadow,
  output logic [6:0]    o_attr
);

  logic [AW-1:0] r_text_addr;
  logic          r_text_rd;
  logic          r_char_vld;
  logic [11:0]   r_font_addr;
  logic          r_font_rd;
  logic          r_font_vld;
  logic [7:0]    r_attr;
  logic [7:0]    r_shadow;
  logic          w_ul;
  logic          w_cur;

  assign w_ul  = r_attr[c_ATTR_UL] && (i_line == 4'(CHAR_H - 1));
  // r_text_addr still holds this cell's index, so it doubles as the cursor compare operand
  assign w_cur = i_cursor_en && i_blink && (r_text_addr == i_cursor_pos) &&
                 ({1'b0, i_cursor_pos} < (AW + 1)'(NCELLS)) &&
                 (({1'b0, i_line} + 5'd2) >= 5'(CHAR_H));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_text_addr <= '0;
      r_text_rd   <= 1'b0;
      r_char_vld  <= 1'b0;
      r_font_addr <= '0;
      r_font_rd   <= 1'b0;
      r_font_vld  <= 1'b0;
      r_attr      <= '0;
      r_shadow    <= '0;
    end else begin
      r_text_rd  <= i_start;
      r_char_vld <= r_text_rd;
      r_font_rd  <= r_char_vld;
      r_font_vld <= r_font_rd;
      if (i_start) r_text_addr <= i_cell;
      if (r_char_vld) begin
        r_attr      <= i_attr_q;
        r_font_addr <= {i_char_q, i_line};
      end
      if (r_font_vld) r_shadow <= (w_ul ? 8'hFF : i_font_q) | (w_cur ? 8'hFF : 8'h00);
    end
  end

  assign o_text_addr = r_text_addr;
  assign o_text_rd   = r_text_rd;
  assign o_font_addr = r_font_addr;
  assign o_font_rd   = r_font_rd;
  assign o_shadow    = r_shadow;
  assign o_attr      = r_attr[6:0];

endmodule
`default_nettype wire

// File: rtl/text_video_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// text_video_engine : parametrised text-mode pixel engine with blinking cursor
// Rev 1.0
// ---------------------------------------------------------------------------
module text_video_engine
  import video_pkg::*;
#(
  parameter int COLS       = 64,
  parameter int ROWS       = 25,
  parameter int CHAR_H     = 10,
  parameter int SCALE_X    = 2,
  parameter int SCALE_Y    = 2,
  parameter int H_ORG      = 162,
  parameter int V_ORG      = 63,
  parameter int CW         = 11,
  parameter int BLINK_LOG2 = 5,
  parameter int AW         = clog2(COLS * ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] hcnt,
  input  logic [CW-1:0] vcnt,
  input  logic          visible,
  input  logic          color_en,
  input  logic          cursor_en,
  input  logic [AW-1:0] cursor_pos,
  output logic [AW-1:0] text_addr,
  output logic          text_rd,
  input  logic [7:0]    char_q,
  input  logic [7:0]    attr_q,
  output logic [11:0]   font_addr,
  output logic          font_rd,
  input  logic [7:0]    font_q,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic          de
);

  localparam int c_CELL_W  = 8 * SCALE_X;
  localparam int c_H_START = H_ORG - c_CELL_W;
  localparam int c_H_END   = H_ORG + COLS * c_CELL_W;
  localparam int c_V_END   = V_ORG + ROWS * CHAR_H * SCALE_Y;
  localparam int c_RXW     = (SCALE_X > 1) ? clog2(SCALE_X) : 1;
  localparam int c_RYW     = (SCALE_Y > 1) ? clog2(SCALE_Y) : 1;
  localparam int c_CLW     = clog2(COLS + 1);

  logic [c_RXW-1:0]      r_rep,  w_rep;
  logic [2:0]            r_bit,  w_bit;
  logic [c_CLW-1:0]      r_col,  w_col;
  logic                  r_hrun, w_hrun;
  logic                  w_last, w_t0, w_hwin, w_vwin;
  logic [AW-1:0]         w_cell;
  logic [c_RYW-1:0]      r_rep_y;
  logic [3:0]            r_line;
  logic [AW-1:0]         r_row_base;
  logic                  r_armed;
  logic [BLINK_LOG2-1:0] r_frame;
  logic [7:0]            r_shift;
  logic [6:0]            r_dattr;
  logic [7:0]            w_shadow;
  logic [6:0]            w_attr;
  logic [7:0]            w_bright;
  rgb_t                  w_ink, w_paper, r_rgb;
  logic                  r_de;

  // Counters describe the pixel currently on hcnt; column index is the fetch column,
  // display runs one cell behind it.
  always_comb begin
    w_rep  = '0;
    w_bit  = '0;
    w_col  = '0;
    w_hrun = 1'b0;
    if (hcnt == CW'(c_H_START)) begin
      w_hrun = 1'b1;
    end else if (r_hrun) begin
      w_hrun = 1'b1;
      w_rep  = r_rep;
      w_bit  = r_bit;
      w_col  = r_col;
      if (r_rep == c_RXW'(SCALE_X - 1)) begin
        w_rep = '0;
        if (r_bit == 3'd7) begin
          w_bit = '0;
          if (r_col == c_CLW'(COLS)) w_hrun = 1'b0;
          else                       w_col  = r_col + 1'b1;
        end else begin
          w_bit = r_bit + 1'b1;
        end
      end else begin
        w_rep = r_rep + 1'b1;
      end
    end
  end

  assign w_hwin = (hcnt >= CW'(H_ORG)) && (hcnt < CW'(c_H_END));
  assign w_vwin = r_armed && (vcnt >= CW'(V_ORG)) && (vcnt < CW'(c_V_END));
  assign w_last = w_hrun && (w_rep == c_RXW'(SCALE_X - 1)) && (w_bit == 3'd7);
  assign w_t0   = w_hrun && w_vwin && (w_rep == '0) && (w_bit == 3'd0) && (w_col < c_CLW'(COLS));
  assign w_cell = r_row_base + AW'(w_col);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rep   <= '0;
      r_bit   <= '0;
      r_col   <= '0;
      r_hrun  <= 1'b0;
      r_shift <= '0;
      r_dattr <= '0;
    end else begin
      r_rep  <= w_rep;
      r_bit  <= w_bit;
      r_col  <= w_col;
      r_hrun <= w_hrun;
      if (w_last) begin
        r_shift <= w_shadow;
        r_dattr <= w_attr;
      end else if (w_hrun && (w_rep == c_RXW'(SCALE_X - 1))) begin
        r_shift <= {r_shift[6:0], 1'b0};
      end
    end
  end

  // Drawing stays off after reset until a fresh V_ORG line re-arms the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rep_y    <= '0;
      r_line     <= '0;
      r_row_base <= '0;
      r_armed    <= 1'b0;
      r_frame    <= '0;
    end else if (hcnt == '0) begin
      if (vcnt == '0) r_frame <= r_frame + 1'b1;
      if (vcnt == CW'(V_ORG)) begin
        r_rep_y    <= '0;
        r_line     <= '0;
        r_row_base <= '0;
        r_armed    <= 1'b1;
      end else if (r_armed && (vcnt > CW'(V_ORG)) && (vcnt < CW'(c_V_END))) begin
        if (r_rep_y == c_RYW'(SCALE_Y - 1)) begin
          r_rep_y <= '0;
          if (r_line == 4'(CHAR_H - 1)) begin
            r_line     <= '0;
            r_row_base <= r_row_base + AW'(COLS);
          end else begin
            r_line <= r_line + 1'b1;
          end
        end else begin
          r_rep_y <= r_rep_y + 1'b1;
        end
      end
    end
  end

  text_cell_fetch #(
    .AW     (AW),
    .CHAR_H (CHAR_H),
    .NCELLS (COLS * ROWS)
  ) u_fetch (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_t0),
    .i_cell       (w_cell),
    .i_line       (r_line),
    .i_cursor_en  (cursor_en),
    .i_blink      (r_frame[BLINK_LOG2-1]),
    .i_cursor_pos (cursor_pos),
    .o_text_addr  (text_addr),
    .o_text_rd    (text_rd),
    .i_char_q     (char_q),
    .i_attr_q     (attr_q),
    .o_font_addr  (font_addr),
    .o_font_rd    (font_rd),
    .i_font_q     (font_q),
    .o_shadow     (w_shadow),
    .o_attr       (w_attr)
  );

  always_comb begin
    w_bright = r_dattr[c_BRIGHT] ? c_BRIGHT_ON : 8'h00;
    w_ink    = '0;
    w_paper  = '0;
    if (color_en) begin
      w_ink.r   = r_dattr[c_INK_MSB]       ? (c_INK_ON | w_bright) : w_bright;
      w_ink.g   = r_dattr[c_INK_MSB - 1]   ? (c_INK_ON | w_bright) : w_bright;
      w_ink.b   = r_dattr[c_INK_LSB]       ? (c_INK_ON | w_bright) : w_bright;
      w_paper.r = r_dattr[c_PAPER_MSB]     ? c_PAPER_ON : 8'h00;
      w_paper.g = r_dattr[c_PAPER_MSB - 1] ? c_PAPER_ON : 8'h00;
      w_paper.b = r_dattr[c_PAPER_LSB]     ? c_PAPER_ON : 8'h00;
    end else begin
      w_ink.g = c_MONO_G;
      w_ink.b = c_MONO_B;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb <= '0;
      r_de  <= 1'b0;
    end else begin
      r_de <= visible;
      if (visible && w_hwin && w_vwin) r_rgb <= r_shift[7] ? w_ink : w_paper;
      else                             r_rgb <= '0;
    end
  end

  assign r  = r_rgb.r;
  assign g  = r_rgb.g;
  assign b  = r_rgb.b;
  assign de = r_de;

endmodule
`default_nettype wire

// File: tb/tb_text_video_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_text_video_engine : directed self-checking bench for text_video_engine
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_text_video_engine;

  localparam int H_ORG = 162;
  localparam int V_ORG = 63;
  localparam int HMAX  = H_ORG + 1026;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcnt, vcnt;
  logic        visible, color_en, cursor_en;
  logic [10:0] cursor_pos;
  logic [10:0] text_addr;
  logic        text_rd;
  logic [7:0]  char_q, attr_q, font_q;
  logic [11:0] font_addr;
  logic        font_rd;
  logic [7:0]  r, g, b;
  logic        de;

  logic [7:0]  char_mem [0:2047];
  logic [7:0]  attr_mem [0:2047];
  logic [7:0]  font_mem [0:4095];

  logic [23:0] pix [0:2047];
  logic        pde [0:2047];
  int          prev_h;
  int          nz_cnt, trd_cnt;
  logic [11:0] first_fa;
  bit          fa_seen;
  logic [10:0] last_ta;
  int          n_chk, n_pass;

  text_video_engine dut (
    .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .visible(visible),
    .color_en(color_en), .cursor_en(cursor_en), .cursor_pos(cursor_pos),
    .text_addr(text_addr), .text_rd(text_rd), .char_q(char_q), .attr_q(attr_q),
    .font_addr(font_addr), .font_rd(font_rd), .font_q(font_q),
    .r(r), .g(g), .b(b), .de(de)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data one clock after the strobe
  always @(posedge clk) begin
    if (text_rd) begin
      char_q <= char_mem[text_addr];
      attr_q <= attr_mem[text_addr];
    end
    if (font_rd) font_q <= font_mem[font_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Presents one hcnt/vcnt pair; first records what the previous pair produced
  task automatic drive(input int h, input int v);
    @(negedge clk);
    if (prev_h >= 0) begin
      pix[prev_h] = {r, g, b};
      pde[prev_h] = de;
      if ({r, g, b} != 24'h0) nz_cnt++;
    end
    if (text_rd) begin
      trd_cnt++;
      last_ta = text_addr;
    end
    if (font_rd && !fa_seen) begin
      first_fa = font_addr;
      fa_seen  = 1'b1;
    end
    hcnt    = 11'(h);
    vcnt    = 11'(v);
    visible = (h >= 100);
    prev_h  = h;
  endtask

  task automatic clear_stats();
    nz_cnt  = 0;
    trd_cnt = 0;
    fa_seen = 1'b0;
    first_fa = '0;
    last_ta = '0;
  endtask

  task automatic run_line(input int v);
    drive(0, v);
    clear_stats();
    for (int h = 1; h <= HMAX + 1; h++) drive(h, v);
  endtask

  task automatic short_lines(input int vfrom, input int vto);
    for (int v = vfrom; v < vto; v++) drive(0, v);
  endtask

  task automatic new_frame();
    drive(0, 0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; prev_h = -1;
    for (int i = 0; i < 2048; i++) begin
      char_mem[i] = 8'h00;
      attr_mem[i] = 8'h00;
    end
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'h00;
    char_mem[0]    = 8'h41; attr_mem[0]    = 8'h07; font_mem[12'h410] = 8'h18;
    font_mem[12'h419] = 8'h5A;
    char_mem[65]   = 8'h42; attr_mem[65]   = 8'h02; font_mem[12'h428] = 8'h81;
    char_mem[128]  = 8'h43; attr_mem[128]  = 8'h70; font_mem[12'h430] = 8'h80;
    char_mem[1599] = 8'h44; attr_mem[1599] = 8'h07; font_mem[12'h449] = 8'h01;

    rst = 1'b0; hcnt = '0; vcnt = '0; visible = 1'b0;
    color_en = 1'b1; cursor_en = 1'b1; cursor_pos = 11'd65;
    repeat (3) @(negedge clk);
    check("reset_rgb", {r, g, b}, 24'h0);
    check("reset_de", de, 1'b0);
    check("reset_text_rd", text_rd, 1'b0);
    check("reset_text_addr", text_addr, 11'd0);
    rst = 1'b1;

    new_frame();
    run_line(V_ORG);
    check("pre_reset_draw", pix[H_ORG+6], 24'hC0C0C0);

    // Reset asserted in the middle of a drawn line
    drive(0, V_ORG + 1);
    for (int h = 1; h <= 300; h++) begin
      drive(h, V_ORG + 1);
      if (h == H_ORG + 8) begin
        rst = 1'b0;
        #1;
        check("midline_rst_rgb", {r, g, b}, 24'h0);
        check("midline_rst_de", de, 1'b0);
        check("midline_rst_text_rd", text_rd, 1'b0);
      end
      if (h == H_ORG + 20) begin
        check("held_rst_rgb", {r, g, b}, 24'h0);
        check("held_rst_de", de, 1'b0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    run_line(V_ORG + 2);
    check("post_rst_black", nz_cnt, 0);
    check("post_rst_no_fetch", trd_cnt, 0);

    // Frame with blink phase off
    new_frame();
    run_line(V_ORG);
    check("cell0_font_addr", first_fa, 12'h410);
    check("cell0_de", pde[H_ORG], 1'b1);
    check("cell0_before_org", pix[H_ORG-1], 24'h0);
    for (int i = 0; i < 16; i++)
      check($sformatf("cell0_pix%0d", i), pix[H_ORG+i],
            (i >= 6 && i <= 9) ? 24'hC0C0C0 : 24'h0);

    attr_mem[0] = 8'h8F;
    short_lines(V_ORG + 1, V_ORG + 18);
    run_line(V_ORG + 18);
    check("ul_font_addr", first_fa, 12'h419);
    for (int i = 0; i < 16; i++)
      check($sformatf("ul_pix%0d", i), pix[H_ORG+i], 24'hFFFFFF);

    short_lines(V_ORG + 19, V_ORG + 36);
    run_line(V_ORG + 36);
    for (int i = 0; i < 16; i++)
      check($sformatf("cur_off_pix%0d", i), pix[H_ORG+16+i],
            (i < 2 || i > 13) ? 24'h00C000 : 24'h0);

    // Advance to blink phase on (frame counter 16)
    repeat (15) new_frame();
    short_lines(V_ORG, V_ORG + 34);
    run_line(V_ORG + 34);
    check("cur_line7_black", nz_cnt, 0);
    short_lines(V_ORG + 35, V_ORG + 36);
    run_line(V_ORG + 36);
    check("cur_on_left_cell", pix[H_ORG+15], 24'h0);
    for (int i = 0; i < 16; i++)
      check($sformatf("cur_on_pix%0d", i), pix[H_ORG+16+i], 24'h00C000);
    check("cur_on_right_cell", pix[H_ORG+32], 24'h0);

    color_en = 1'b0;
    short_lines(V_ORG + 37, V_ORG + 40);
    run_line(V_ORG + 40);
    check("mono_font_addr", first_fa, 12'h430);
    for (int i = 0; i < 16; i++)
      check($sformatf("mono_pix%0d", i), pix[H_ORG+i], (i < 2) ? 24'h00C00B : 24'h0);
    color_en = 1'b1;

    short_lines(V_ORG + 41, V_ORG + 499);
    run_line(V_ORG + 499);
    check("last_text_addr", last_ta, 11'd1599);
    check("last_cell_pix14", pix[H_ORG+1022], 24'hC0C0C0);
    check("last_cell_pix15", pix[H_ORG+1023], 24'hC0C0C0);
    check("right_edge_black", pix[H_ORG+1024], 24'h0);

    run_line(V_ORG + 500);
    check("below_window_no_fetch", trd_cnt, 0);
    check("below_window_black", nz_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/text_video_engine.md
Name: text_video_engine

Overview:
- Parametrised text-mode pixel engine for the HDMI path. Replaces the fixed 64-column, 10-line, 2x-scaled character generator.
- Consumes hcnt/vcnt/visible from the timing generator and fetches character code, attribute and font row through synchronous-read memory ports. Produces registered RGB.
- Adds configurable geometry, a hardware blinking cursor, blink-phase generation and incremental row/line counters, so there is no divide/modulo in the datapath.
- All logic runs on pixclk.

Parameters:
- COLS, 64, characters per row
- ROWS, 25, character rows
- CHAR_H, 10, font scanlines per character (1..16)
- SCALE_X, 2, horizontal pixel replication (8*SCALE_X >= 4 required)
- SCALE_Y, 2, vertical line replication
- H_ORG, 162, hcnt of first active text pixel
- V_ORG, 63, vcnt of first active text line
- CW, 11, timing counter width
- BLINK_LOG2, 5, cursor blink period = 2^BLINK_LOG2 frames
- AW, clog2(COLS*ROWS), text address width

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-low
- hcnt  in  CW  horizontal position
- vcnt  in  CW  vertical position
- visible  in  1  timing-generator active video
- color_en  in  1  1 = attribute colour, 0 = monochrome green
- cursor_en  in  1  hardware cursor enable
- cursor_pos  in  AW  cursor cell index
- text_addr  out  AW  shared address to char and attribute RAMs
- text_rd  out  1  read strobe
- char_q  in  8  char RAM data, valid 1 clk after text_rd
- attr_q  in  8  attribute RAM data, valid 1 clk after text_rd
- font_addr  out  12  {code, line[3:0]}
- font_rd  out  1  font ROM read strobe
- font_q  in  8  font row, valid 1 clk after font_rd, MSB leftmost
- r, g, b  out  8 each  pixel colour
- de  out  1  registered visible

Behaviour:
- Reset: r/g/b = 0, de = 0, text_rd = font_rd = 0, addresses 0. All counters, shift and shadow registers 0. Blink counter 0.
- Text window:
  - hcnt in [H_ORG, H_ORG + COLS*8*SCALE_X)
  - vcnt in [V_ORG, V_ORG + ROWS*CHAR_H*SCALE_Y)
  - Outside the window but visible: black. Outside visible: black.
- Vertical counters update at hcnt == 0:
  - vcnt == V_ORG clears rep_y, line, row and row_base.
  - Otherwise in window: rep_y increments and wraps at SCALE_Y.
  - On rep_y wrap, line increments and wraps at CHAR_H.
  - On line wrap, row += 1 and row_base += COLS.
- Horizontal: sub-pixel and column counters start at hcnt == H_ORG - 8*SCALE_X (lead-in cell, fetches column 0).
- Fetch pipeline, per cell, relative to cell start t0:
  - t0: text_addr = row_base + col; text_rd = 1.
  - t0+1: latch code and attribute; font_addr = {code, line}; font_rd = 1.
  - t0+2: shadow = underline_line ? 8'hFF : font_q; then OR 8'hFF if cursor_hit.
  - Last sub-pixel of cell: shadow and attribute move into the display registers.
- Derived conditions:
  - underline_line = attr[7] and line == CHAR_H-1.
  - cursor_hit = cursor_en and blink_phase and (row_base + col == cursor_pos) and line >= CHAR_H-2.
  - cursor_pos >= COLS*ROWS never hits.
- Pixel bit = disp[7 - subpix/SCALE_X]. The divide is implemented as a replication counter, not a divider.
- Colour mode, color_en = 1:
  - bright = attr[3] ? 8'h3F : 8'h00.
  - Ink channel = attr[2:0] bit ? (8'hC0 | bright) : bright.
  - Paper channel = attr[6:4] bit ? 8'hFF : 8'h00.
- Monochrome mode, color_en = 0: ink = (00, C0, 0B); paper = (00, 00, 00).
- Latency: r/g/b/de registered. The pixel for hcnt = H_ORG appears the cycle after hcnt = H_ORG is presented. Sync delay is the caller's responsibility.
- Blink: the frame counter increments at hcnt == 0 and vcnt == 0. blink_phase = frame_cnt[BLINK_LOG2-1].
- Rows >= ROWS: no fetch, black.
- Reset mid-frame: black output until the next vcnt == V_ORG line start. No partial frame is drawn.
- color_en and cursor_en are sampled per pixel and may change at any time without glitching fetch timing.

Decomposition:
- Shared package video_pkg holds:
  - attribute bit positions (UL = 7, PAPER = 6:4, BRIGHT = 3, INK = 2:0)
  - colour constants (8'hC0, 8'h3F, mono 8'hC0 / 8'h0B)
  - clog2 function
- Sub-module text_cell_fetch holds the t0..t0+2 pipeline, shadow register and cursor/underline overlay.
- The top holds the counters, shifter and colour mux.

Test Plan:
- Reset held low mid-line -> r/g/b = 0, de = 0, text_rd = 0; after release, first nonzero pixel only on the frame after vcnt == V_ORG.
- Cell 0: char 0x41, attr 0x07, font row 0 = 0x18, color_en = 1 -> font_addr = 0x410; pixels H_ORG+6..H_ORG+9 = (C0, C0, C0), others = 0.
- Cell 0: attr 0x8F, line 9 -> font_addr = 0x419; all 16 pixels = (FF, FF, FF) regardless of font_q.
- cursor_en = 1, cursor_pos = 65 (row 1, col 1) -> lines 8-9 of that cell solid ink in frames 16..31; normal glyph in frames 0..15.
- color_en = 0, attr 0x70, font row 0x80 -> first 2 pixels (00, C0, 0B), rest (00, 00, 00).
- Last cell, row 24 col 63 -> text_addr = 1599; hcnt = H_ORG + 1024 and vcnt = V_ORG + 500 are black with no text_rd issued.
